// File: rtl/dbg_capture_pkg.sv
// Shared types and constants for the debug-word capture UART.
package dbg_capture_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned FRAME_BITS     = 10;
  localparam int unsigned BYTES_PER_WORD = 2;
  localparam int unsigned DATA_BITS      = FRAME_BITS - 2;
  localparam int unsigned DBG_W          = 16;
  localparam int unsigned TIMER_W        = 16;
  localparam int unsigned BIT_W          = 3;
  localparam int unsigned BYTE_W         = 1;

endpackage

// File: rtl/dbg_fifo.sv
// Show-ahead synchronous FIFO; full is judged on the pre-edge level, so a
// push into a full FIFO is dropped even when a pop happens on the same edge.
module dbg_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_c,
  output logic                  full_c,
  output logic                  empty_c,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok_c;
  logic             pop_ok_c;

  always_comb begin
    full_c    = (level_q == LVL_W'(DEPTH));
    empty_c   = (level_q == '0);
    push_ok_c = push_i && !full_c;
    pop_ok_c  = pop_i && !empty_c;
    rdata_c   = mem_q[rd_ptr_q];
    level_o   = level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dbg_capture.sv
// Captures every change of the CPU debug word into a FIFO and streams each
// word out over an 8N1 UART as two bytes, high byte first.
module dbg_capture
  import dbg_capture_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DBG_W-1:0]      dbg_in,
  output logic                  tx,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy
);

  localparam logic [TIMER_W-1:0] RELOAD    = TIMER_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [BYTE_W-1:0]  LAST_BYTE = BYTE_W'(BYTES_PER_WORD - 1);

  logic [DBG_W-1:0]   dbg_q;
  logic               ovf_q;
  logic               change_c;
  logic               pop_c;
  logic               fifo_full_c;
  logic               fifo_empty_c;
  logic [DBG_W-1:0]   fifo_rdata_c;

  tx_state_e          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic [DBG_W-1:0]   word_q, word_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;

  assign change_c = (dbg_in != dbg_q);

  // Overflow is sticky: only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dbg_q <= dbg_in;
      if (change_c && fifo_full_c) ovf_q <= 1'b1;
    end
  end

  dbg_fifo #(
    .WIDTH      (DBG_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (change_c),
    .pop_i   (pop_c),
    .wdata_i (dbg_in),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .level_o (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    pop_c   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          word_d  = fifo_rdata_c;
          byte_d  = '0;
          timer_d = RELOAD;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (timer_q == '0) begin
          bit_d   = '0;
          timer_d = RELOAD;
          state_d = TX_DATA;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      TX_DATA: begin
        if (timer_q == '0) begin
          timer_d = RELOAD;
          if (bit_q == LAST_BIT) state_d = TX_STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      TX_STOP: begin
        // Next byte of the same word follows with no gap; a queued word
        // is started on the very edge the last stop bit ends.
        if (timer_q == '0) begin
          if (byte_q != LAST_BYTE) begin
            byte_d  = byte_q + BYTE_W'(1);
            timer_d = RELOAD;
            state_d = TX_START;
          end else if (!fifo_empty_c) begin
            pop_c   = 1'b1;
            word_d  = fifo_rdata_c;
            byte_d  = '0;
            timer_d = RELOAD;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Byte 0 is the high byte, so its bits live at word index {1, bit}.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != TX_IDLE);
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = word_d[{~byte_d, bit_d}];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_dbg_capture.sv
// Self-checking bench for dbg_capture against a word/queue-level reference.
module tb_dbg_capture;

  localparam int unsigned CD       = 4;
  localparam int unsigned DL2      = 2;
  localparam int unsigned DEPTH    = 1 << DL2;
  localparam int          WORD_CYC = 20 * CD;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [15:0]     dbg_in = 16'h0000;
  logic            tx;
  logic [DL2:0]    level;
  logic            overflow;
  logic            busy;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] m_prev = 16'h0000;
  logic [15:0] m_q[$];
  logic        m_ovf = 1'b0;
  logic        m_act = 1'b0;
  logic [15:0] m_word = 16'h0000;
  int          m_t = 0;

  dbg_capture #(.CLK_DIV(CD), .DEPTH_LOG2(DL2)) dut (
    .clk      (clk),
    .rst      (rst),
    .dbg_in   (dbg_in),
    .tx       (tx),
    .level    (level),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Predict the state after the next edge given this cycle's inputs.
  function automatic void model_step(input logic r, input logic [15:0] d);
    int lvl;
    if (r) begin
      m_prev = 16'h0000;
      m_q.delete();
      m_ovf = 1'b0;
      m_act = 1'b0;
      m_t   = 0;
      return;
    end
    lvl = m_q.size();
    if (m_act) begin
      m_t++;
      if (m_t == WORD_CYC) m_act = 1'b0;
    end
    if (!m_act && lvl > 0) begin
      m_word = m_q.pop_front();
      m_act  = 1'b1;
      m_t    = 0;
    end
    if (d != m_prev) begin
      if (lvl == DEPTH) m_ovf = 1'b1;
      else              m_q.push_back(d);
    end
    m_prev = d;
  endfunction

  function automatic logic exp_tx();
    int bp, w;
    logic [7:0] b;
    if (!m_act) return 1'b1;
    bp = m_t / CD;
    w  = bp % 10;
    b  = (bp < 10) ? m_word[15:8] : m_word[7:0];
    if (w == 0) return 1'b0;
    if (w == 9) return 1'b1;
    return b[w-1];
  endfunction

  function automatic logic [5:0] exp_vec();
    return {exp_tx(), m_act, m_ovf, 3'(m_q.size())};
  endfunction

  task automatic tick(input logic r, input logic [15:0] d);
    rst    = r;
    dbg_in = d;
    model_step(r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, 16'h0000);
    tick(1'b1, 16'h0000);
  endtask

  task automatic test_reset();
    tick(1'b1, 16'h1234);
    tick(1'b1, 16'hBEEF);
    n_run++;
    if ({tx, busy, overflow, level} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_values: got {tx,busy,ovf,level}=%b exp 100000", {tx, busy, overflow, level});
    end
    tick(1'b0, 16'h0000);
    n_run++;
    if ({tx, busy, overflow, level} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_first_zero: got %b exp 100000", {tx, busy, overflow, level});
    end
  endtask

  task automatic test_single_word();
    logic [19:0] seq;
    seq = 20'b0101001011_0010110101;
    do_reset();
    tick(1'b0, 16'hA55A);
    n_run++;
    if ({tx, busy, level} !== 5'b10001) begin
      n_fail++;
      $display("FAIL single_push: got {tx,busy,level}=%b exp 10001", {tx, busy, level});
    end
    for (int i = 0; i < WORD_CYC; i++) begin
      tick(1'b0, 16'hA55A);
      n_run++;
      if ({tx, busy} !== {seq[19 - i / CD], 1'b1}) begin
        n_fail++;
        $display("FAIL single_frame cyc=%0d: got {tx,busy}=%b exp %b", i, {tx, busy}, {seq[19 - i / CD], 1'b1});
      end
      n_run++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_model cyc=%0d: got %b exp %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
    tick(1'b0, 16'hA55A);
    n_run++;
    if ({tx, busy, level} !== 5'b10000) begin
      n_fail++;
      $display("FAIL single_end: got {tx,busy,level}=%b exp 10000", {tx, busy, level});
    end
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, 16'h0000);
      n_run++;
      if ({tx, busy, overflow, level} !== exp_vec() || tx !== 1'b1 || level !== 3'd0) begin
        n_fail++;
        $display("FAIL constant cyc=%0d: got %b exp %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
  endtask

  task automatic test_burst_overflow();
    logic [15:0] base;
    base = 16'($urandom_range(1, 60000));
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b0, base + 16'(i));
    n_run++;
    if ({busy, overflow, level} !== 5'b11100) begin
      n_fail++;
      $display("FAIL burst_fill: got {busy,ovf,level}=%b exp 11100", {busy, overflow, level});
    end
    for (int i = 0; i < 5 * WORD_CYC - 5; i++) begin
      tick(1'b0, base + 16'd5);
      n_run++;
      if ({tx, busy, overflow, level} !== exp_vec() || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_stream cyc=%0d: got %b exp %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
    tick(1'b0, base + 16'd5);
    n_run++;
    if ({tx, busy, overflow, level} !== 6'b101000) begin
      n_fail++;
      $display("FAIL burst_drained: got %b exp 101000", {tx, busy, overflow, level});
    end
    for (int i = 0; i < 20; i++) tick(1'b0, base + 16'd5);
    n_run++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b exp 1", overflow);
    end
  endtask

  task automatic test_push_pop();
    logic [15:0] base;
    int budget;
    base = 16'($urandom_range(1, 60000));
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, base + 16'(i));
    n_run++;
    if (level !== 3'd2) begin
      n_fail++;
      $display("FAIL pushpop_setup: got level=%0d exp 2", level);
    end
    budget = 200;
    while (!(m_act && m_t == WORD_CYC - 1) && budget > 0) begin
      tick(1'b0, base + 16'd2);
      budget--;
    end
    n_run++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL pushpop_wait: got budget=0 exp word end");
    end
    tick(1'b0, base + 16'd3);
    n_run++;
    if ({busy, level} !== 4'b1010 || {tx, busy, overflow, level} !== exp_vec()) begin
      n_fail++;
      $display("FAIL pushpop_same_edge: got {busy,level}=%b exp 1010", {busy, level});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] base;
    int budget;
    base = 16'($urandom_range(1, 60000));
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b0, base + 16'(i));
    budget = 100;
    while (m_t != 4 * CD + 1 && budget > 0) begin
      tick(1'b0, base + 16'd5);
      budget--;
    end
    n_run++;
    if (budget == 0 || {tx, busy, overflow, level} !== exp_vec()) begin
      n_fail++;
      $display("FAIL midreset_pre: got %b exp %b budget=%0d", {tx, busy, overflow, level}, exp_vec(), budget);
    end
    tick(1'b1, base + 16'd5);
    n_run++;
    if ({tx, busy, overflow, level} !== 6'b100000) begin
      n_fail++;
      $display("FAIL midreset_abort: got %b exp 100000", {tx, busy, overflow, level});
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic        r;
    int          burst;
    d = 16'h0000;
    burst = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 799) == 0);
      if (burst == 0 && $urandom_range(0, 299) == 0) burst = 6;
      if (burst > 0) begin
        d = d + 16'($urandom_range(1, 9));
        burst--;
      end else if ($urandom_range(0, 99) < 3) begin
        d = 16'($urandom);
      end
      tick(r, d);
      n_run++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d: got %b exp %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_constant();
    test_burst_overflow();
    test_push_pop();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
